// File: rtl/id_stage_pipe_if.sv
// Decode-stage bus: IF/ID input, W-stage writeback, hazard-unit controls and ID/EX outputs.
// ID_PERF_CNT_EN adds the stallCntD performance counter to the bus.
interface id_stage_pipe_if #(
  parameter int XLEN  = 32,
  parameter int NREGS = 32
);
  localparam int RW = $clog2(NREGS);

  logic [31:0]     instrD;
  logic            validD;
  logic            readyD;
  logic            stallE;
  logic            flushE;
  logic            regwriteW;
  logic [RW-1:0]   rdW;
  logic [XLEN-1:0] resultW;
  logic            validE;
  logic [6:0]      opE;
  logic [2:0]      funct3E;
  logic            funct7bE;
  logic [RW-1:0]   rs1E;
  logic [RW-1:0]   rs2E;
  logic [RW-1:0]   rdE;
  logic [XLEN-1:0] rd1E;
  logic [XLEN-1:0] rd2E;
  logic [XLEN-1:0] immE;
  logic            loadUseD;
`ifdef ID_PERF_CNT_EN
  logic [31:0]     stallCntD;
`endif

  modport master (
    output instrD, validD, stallE, flushE, regwriteW, rdW, resultW,
    input  readyD, validE, opE, funct3E, funct7bE, rs1E, rs2E, rdE,
    input  rd1E, rd2E, immE, loadUseD
`ifdef ID_PERF_CNT_EN
    , input stallCntD
`endif
  );

  modport slave (
    input  instrD, validD, stallE, flushE, regwriteW, rdW, resultW,
    output readyD, validE, opE, funct3E, funct7bE, rs1E, rs2E, rdE,
    output rd1E, rd2E, immE, loadUseD
`ifdef ID_PERF_CNT_EN
    , output stallCntD
`endif
  );
endinterface

// File: rtl/id_stage_pipe.sv
// Decode stage: register file, immediate generation, load-use interlock and ID/EX register.
// Optional stall-cycle counter built when ID_PERF_CNT_EN is defined.
module id_stage_pipe #(
  parameter int XLEN   = 32,
  parameter int NREGS  = 32,
  parameter int BYPASS = 1
) (
  input logic          CLK,
  input logic          RST,
  id_stage_pipe_if.slave bus
);
  localparam int RW = $clog2(NREGS);

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  logic [XLEN-1:0] rf [NREGS];
  logic [6:0]      opD;
  logic [RW-1:0]   rs1D;
  logic [RW-1:0]   rs2D;
  logic [RW-1:0]   rdD;
  logic [XLEN-1:0] rd1D;
  logic [XLEN-1:0] rd2D;
  logic [31:0]     imm32;
  logic [XLEN-1:0] immD;
  logic            rs2_used;
  logic            load_use;
  logic            ready;

  assign opD  = bus.instrD[6:0];
  assign rs1D = bus.instrD[15 +: RW];
  assign rs2D = bus.instrD[20 +: RW];
  assign rdD  = bus.instrD[7 +: RW];

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      for (int unsigned i = 0; i < NREGS; i++) rf[i] <= '0;
    end else if (bus.regwriteW && bus.rdW != '0) begin
      rf[bus.rdW] <= bus.resultW;
    end
  end

  // x0 is forced to zero on read; write-through only when BYPASS is set
  always_comb begin
    rd1D = rf[rs1D];
    if (rs1D == '0)
      rd1D = '0;
    else if (BYPASS != 0 && bus.regwriteW && bus.rdW == rs1D)
      rd1D = bus.resultW;

    rd2D = rf[rs2D];
    if (rs2D == '0)
      rd2D = '0;
    else if (BYPASS != 0 && bus.regwriteW && bus.rdW == rs2D)
      rd2D = bus.resultW;
  end

  always_comb begin
    imm32 = '0;
    case (opD)
      OP_LOAD, OP_IMM, OP_JALR:
        imm32 = {{20{bus.instrD[31]}}, bus.instrD[31:20]};
      OP_STORE:
        imm32 = {{20{bus.instrD[31]}}, bus.instrD[31:25], bus.instrD[11:7]};
      OP_BRANCH:
        imm32 = {{19{bus.instrD[31]}}, bus.instrD[31], bus.instrD[7],
                 bus.instrD[30:25], bus.instrD[11:8], 1'b0};
      OP_LUI, OP_AUIPC:
        imm32 = {bus.instrD[31:12], 12'b0};
      OP_JAL:
        imm32 = {{11{bus.instrD[31]}}, bus.instrD[31], bus.instrD[19:12],
                 bus.instrD[20], bus.instrD[30:21], 1'b0};
      default:
        imm32 = '0;
    endcase
    immD = XLEN'($signed(imm32));
  end

  assign rs2_used = (opD == OP_R) || (opD == OP_STORE) || (opD == OP_BRANCH);

  // The bubble inserted on a hit clears validE, so the interlock self-limits to one cycle
  assign load_use = bus.validD && bus.validE && bus.opE == OP_LOAD && bus.rdE != '0 &&
                    (bus.rdE == rs1D || (rs2_used && bus.rdE == rs2D));
  assign ready    = !bus.stallE && !load_use;

  assign bus.loadUseD = load_use;
  assign bus.readyD   = ready;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      bus.validE   <= 1'b0;
      bus.opE      <= '0;
      bus.funct3E  <= '0;
      bus.funct7bE <= 1'b0;
      bus.rs1E     <= '0;
      bus.rs2E     <= '0;
      bus.rdE      <= '0;
      bus.rd1E     <= '0;
      bus.rd2E     <= '0;
      bus.immE     <= '0;
    end else if (bus.flushE) begin
      bus.validE <= 1'b0;
    end else if (bus.stallE) begin
      bus.validE <= bus.validE;
    end else if (load_use) begin
      bus.validE <= 1'b0;
    end else begin
      bus.validE   <= bus.validD;
      bus.opE      <= opD;
      bus.funct3E  <= bus.instrD[14:12];
      bus.funct7bE <= bus.instrD[30];
      bus.rs1E     <= rs1D;
      bus.rs2E     <= rs2D;
      bus.rdE      <= rdD;
      bus.rd1E     <= rd1D;
      bus.rd2E     <= rd2D;
      bus.immE     <= immD;
    end
  end

`ifdef ID_PERF_CNT_EN
  always_ff @(posedge CLK or posedge RST) begin
    if (RST)
      bus.stallCntD <= '0;
    else if (bus.validD && !ready && bus.stallCntD != '1)
      bus.stallCntD <= bus.stallCntD + 32'd1;
  end
`endif
endmodule

// File: tb/tb_id_stage_pipe.sv
// Scoreboard bench for id_stage_pipe; also checks stallCntD when ID_PERF_CNT_EN is defined.
module tb_id_stage_pipe;
  localparam int XLEN  = 32;
  localparam int NREGS = 32;

  logic CLK = 1'b0;
  logic RST = 1'b1;
  always #5 CLK = ~CLK;

  id_stage_pipe_if #(.XLEN(XLEN), .NREGS(NREGS)) bus ();
  id_stage_pipe #(.XLEN(XLEN), .NREGS(NREGS), .BYPASS(1)) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus.slave)
  );

  typedef struct packed {
    logic [6:0]  op;
    logic [2:0]  f3;
    logic        f7b;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [31:0] rd1;
    logic [31:0] rd2;
    logic [31:0] imm;
  } exp_t;

  exp_t        q[$];
  exp_t        last;
  logic [31:0] mrf [32];
  logic        mvalid;
  logic [31:0] mcnt;
  int          nchecks = 0;
  int          nerr = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    nchecks++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] enc_r(input logic [4:0] rd, input logic [4:0] rs1,
                                        input logic [4:0] rs2, input logic [6:0] f7);
    return {f7, rs2, rs1, 3'b000, rd, 7'h33};
  endfunction
  function automatic logic [31:0] enc_i(input logic [6:0] op, input logic [4:0] rd,
                                        input logic [4:0] rs1, input logic [11:0] imm);
    return {imm, rs1, 3'b010, rd, op};
  endfunction
  function automatic logic [31:0] enc_s(input logic [4:0] rs1, input logic [4:0] rs2,
                                        input logic [11:0] imm);
    return {imm[11:5], rs2, rs1, 3'b010, imm[4:0], 7'h23};
  endfunction
  function automatic logic [31:0] enc_b(input logic [4:0] rs1, input logic [4:0] rs2,
                                        input logic [12:0] imm);
    return {imm[12], imm[10:5], rs2, rs1, 3'b001, imm[4:1], imm[11], 7'h63};
  endfunction
  function automatic logic [31:0] enc_u(input logic [6:0] op, input logic [4:0] rd,
                                        input logic [19:0] imm);
    return {imm, rd, op};
  endfunction
  function automatic logic [31:0] enc_j(input logic [4:0] rd, input logic [20:0] imm);
    return {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'h6f};
  endfunction

  task automatic model_clear();
    for (int i = 0; i < 32; i++) mrf[i] = '0;
    mvalid = 1'b0;
    mcnt   = '0;
    last   = '0;
    q.delete();
  endtask

  task automatic do_reset();
    @(negedge CLK);
    RST = 1'b1;
    #1;
    chk("rst_validE", bus.validE, 1'b0);
    chk("rst_rd1E", bus.rd1E, 32'h0);
    chk("rst_immE", bus.immE, 32'h0);
    chk("rst_rdE", bus.rdE, 5'd0);
`ifdef ID_PERF_CNT_EN
    chk("rst_stallCntD", bus.stallCntD, 32'h0);
`endif
    model_clear();
    @(negedge CLK);
    RST = 1'b0;
  endtask

  // One clock: drive at negedge, check combinational outputs, then registered outputs after posedge
  task automatic step(input logic vd, input logic [31:0] ins, input logic [31:0] eimm,
                      input logic st = 1'b0, input logic fl = 1'b0, input logic we = 1'b0,
                      input logic [4:0] rw = 5'd0, input logic [31:0] res = 32'h0);
    logic [4:0] rs1, rs2;
    logic       used, lu, cap;
    exp_t       e;
    @(negedge CLK);
    bus.validD = vd;  bus.instrD = ins; bus.stallE = st; bus.flushE = fl;
    bus.regwriteW = we; bus.rdW = rw;   bus.resultW = res;
    rs1  = ins[19:15];
    rs2  = ins[24:20];
    used = (ins[6:0] == 7'h33) || (ins[6:0] == 7'h23) || (ins[6:0] == 7'h63);
    lu   = vd && mvalid && last.op == 7'h03 && last.rd != 5'd0 &&
           (last.rd == rs1 || (used && last.rd == rs2));
    #1;
    chk("loadUseD", bus.loadUseD, lu);
    chk("readyD", bus.readyD, !st && !lu);
    e.op  = ins[6:0];   e.f3 = ins[14:12]; e.f7b = ins[30];
    e.rs1 = rs1;        e.rs2 = rs2;       e.rd  = ins[11:7];
    e.rd1 = (rs1 == 5'd0) ? 32'h0 : (we && rw == rs1) ? res : mrf[rs1];
    e.rd2 = (rs2 == 5'd0) ? 32'h0 : (we && rw == rs2) ? res : mrf[rs2];
    e.imm = eimm;
    cap = 1'b0;
    if (fl)       mvalid = 1'b0;
    else if (st)  mvalid = mvalid;
    else if (lu)  mvalid = 1'b0;
    else begin
      mvalid = vd;
      if (vd) begin q.push_back(e); cap = 1'b1; end
    end
    if (vd && (st || lu) && mcnt != 32'hFFFF_FFFF) mcnt = mcnt + 32'd1;
    @(posedge CLK);
    if (we && rw != 5'd0) mrf[rw] = res;
    #1;
    chk("validE", bus.validE, mvalid);
    if (cap) last = q.pop_front();
    if (mvalid) begin
      chk("opE", bus.opE, last.op);
      chk("funct3E", bus.funct3E, last.f3);
      chk("funct7bE", bus.funct7bE, last.f7b);
      chk("rs1E", bus.rs1E, last.rs1);
      chk("rs2E", bus.rs2E, last.rs2);
      chk("rdE", bus.rdE, last.rd);
      chk("rd1E", bus.rd1E, last.rd1);
      chk("rd2E", bus.rd2E, last.rd2);
      chk("immE", bus.immE, last.imm);
    end
`ifdef ID_PERF_CNT_EN
    chk("stallCntD", bus.stallCntD, mcnt);
`endif
  endtask

  logic [31:0] lw7, add877;

  initial begin
    bus.validD = 0; bus.instrD = '0; bus.stallE = 0; bus.flushE = 0;
    bus.regwriteW = 0; bus.rdW = '0; bus.resultW = '0;
    model_clear();
    lw7    = enc_i(7'h03, 5'd7, 5'd1, 12'h000);
    add877 = enc_r(5'd8, 5'd7, 5'd7, 7'h00);
    do_reset();

    // R-type decode, then register writes feeding later reads
    step(1, enc_r(5'd3, 5'd1, 5'd2, 7'h00), 32'h0);
    step(0, '0, 32'h0, 0, 0, 1, 5'd1, 32'h0000_0011);
    step(1, enc_r(5'd4, 5'd1, 5'd2, 7'h20), 32'h0, 0, 0, 1, 5'd2, 32'h0000_0022);
    // Write-through: x5 written and read in the same cycle
    step(1, enc_i(7'h13, 5'd6, 5'd5, 12'hFFF), 32'hFFFF_FFFF, 0, 0, 1, 5'd5, 32'hDEAD_BEEF);

    // Immediate formats and boundaries
    step(1, enc_s(5'd1, 5'd2, 12'hFF8), 32'hFFFF_FFF8);
    step(1, enc_b(5'd1, 5'd2, 13'h1FFC), 32'hFFFF_FFFC);
    step(1, enc_b(5'd1, 5'd2, 13'h0FFE), 32'h0000_0FFE);
    step(1, enc_u(7'h37, 5'd9, 20'hABCDE), 32'hABCD_E000);
    step(1, enc_u(7'h17, 5'd10, 20'h80000), 32'h8000_0000);
    step(1, enc_j(5'd1, 21'h1FFFFE), 32'hFFFF_FFFE);
    step(1, enc_j(5'd1, 21'h000800), 32'h0000_0800);
    step(1, enc_i(7'h67, 5'd1, 5'd2, 12'h7FF), 32'h0000_07FF);
    step(1, 32'hFFFF_F00B, 32'h0);

    // Load-use: one-cycle interlock then acceptance
    step(1, lw7, 32'h0);
    step(1, add877, 32'h0);
    step(1, add877, 32'h0);
    // rs2 field matches but is unused by I-type: no interlock
    step(1, lw7, 32'h0);
    step(1, enc_i(7'h13, 5'd9, 5'd1, 12'h007), 32'h0000_0007);
    // store uses rs2
    step(1, lw7, 32'h0);
    step(1, enc_s(5'd1, 5'd7, 12'h000), 32'h0);
    step(1, enc_s(5'd1, 5'd7, 12'h000), 32'h0);
    // load to x0 never interlocks
    step(1, enc_i(7'h03, 5'd0, 5'd1, 12'h000), 32'h0);
    step(1, enc_r(5'd8, 5'd0, 5'd0, 7'h00), 32'h0);
    // flush wins over load-use; instruction still refused
    step(1, lw7, 32'h0);
    step(1, add877, 32'h0, 0, 1);
    step(1, add877, 32'h0);

    // x0 writes are discarded, including same-cycle
    step(0, '0, 32'h0, 0, 0, 1, 5'd0, 32'h0000_1234);
    step(1, enc_r(5'd1, 5'd0, 5'd0, 7'h00), 32'h0, 0, 0, 1, 5'd0, 32'h0000_1234);

    // stallE holds E for 3 cycles even as x5 is rewritten, then flush+stall clears validE
    step(1, enc_i(7'h13, 5'd6, 5'd5, 12'h001), 32'h0000_0001);
    step(1, add877, 32'h0, 1, 0, 1, 5'd5, 32'h5555_0000);
    step(1, add877, 32'h0, 1);
    step(1, add877, 32'h0, 1);
    step(1, add877, 32'h0, 1, 1);
    step(0, '0, 32'h0);

    // Counter scenario: 3 load-use stalls plus 2 stallE cycles
    do_reset();
    for (int k = 0; k < 3; k++) begin
      step(1, lw7, 32'h0);
      step(1, add877, 32'h0);
      step(1, add877, 32'h0);
    end
    step(1, enc_i(7'h13, 5'd6, 5'd5, 12'h001), 32'h0000_0001, 1);
    step(1, enc_i(7'h13, 5'd6, 5'd5, 12'h001), 32'h0000_0001, 1);
`ifdef ID_PERF_CNT_EN
    chk("stallCntD_total", bus.stallCntD, 32'd5);
`endif
    // Reset while a valid instruction sits stalled in E
    step(1, lw7, 32'h0);
    step(1, add877, 32'h0, 1);
    do_reset();
    // Interlock restarts from an empty E
    step(1, add877, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", nchecks, nerr);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end
endmodule
